// File: rtl/mem_arb_pkg.sv
// Shared types for the SRAM port arbiter: default sizes, port index, arbiter state, lock counter width.
// Pure declarations, no logic.
package mem_arb_pkg;

  localparam int unsigned DefNumPorts  = 2;
  localparam int unsigned DefAddrWidth = 13;
  localparam int unsigned DefDataWidth = 64;
  localparam int unsigned DefMaxLock   = 16;
  localparam int unsigned PortIdxWidth = $clog2(DefNumPorts);

  typedef logic [PortIdxWidth-1:0] port_idx_t;

  typedef enum logic {
    ARB,
    LOCKED
  } state_e;

  // Counter must hold MaxLock itself, not just MaxLock-1.
  function automatic int unsigned lock_cnt_width(input int unsigned max_lock);
    return $clog2(max_lock + 1);
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side mem bus of the SRAM port arbiter, one lane per port.
// Grant is same-cycle; rvalid/rdata arrive one cycle after the grant.
interface sram_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned NumPorts  = DefNumPorts,
  parameter int unsigned AddrWidth = DefAddrWidth,
  parameter int unsigned DataWidth = DefDataWidth
);

  logic [NumPorts-1:0]                  req;
  logic [NumPorts-1:0]                  lock;
  logic [NumPorts-1:0][AddrWidth-1:0]   addr;
  logic [NumPorts-1:0]                  we;
  logic [NumPorts-1:0][DataWidth-1:0]   wdata;
  logic [NumPorts-1:0][DataWidth/8-1:0] be;
  logic [NumPorts-1:0]                  gnt;
  logic [NumPorts-1:0]                  rvalid;
  logic [DataWidth-1:0]                 rdata;

  modport master (output req, lock, addr, we, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req, lock, addr, we, wdata, be, output gnt, rvalid, rdata);

endinterface

// File: rtl/sram_rr_picker.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping modulo NumPorts.
// Zero latency; never stalls.
module sram_rr_picker #(
  parameter  int unsigned NumPorts = 2,
  localparam int unsigned IdxW     = $clog2(NumPorts)
) (
  input  logic [NumPorts-1:0] req_i,
  input  logic [IdxW-1:0]     ptr_i,
  output logic [NumPorts-1:0] gnt_o,
  output logic [IdxW-1:0]     idx_o,
  output logic                vld_o
);

  always_comb begin
    int unsigned p;
    logic [IdxW-1:0] pi;
    p     = 0;
    pi    = '0;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int unsigned k = 0; k < NumPorts; k++) begin
      p  = (32'(ptr_i) + k) % NumPorts;
      pi = IdxW'(p);
      if (!vld_o && req_i[pi]) begin
        vld_o     = 1'b1;
        gnt_o[pi] = 1'b1;
        idx_o     = pi;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin share of one single-port SRAM between NumPorts requesters, with bounded ownership lock.
// Grant same cycle as req, rvalid one cycle later to the issuing port; losers simply hold req.
module sram_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NumPorts  = DefNumPorts,
  parameter int unsigned AddrWidth = DefAddrWidth,
  parameter int unsigned DataWidth = DefDataWidth,
  parameter int unsigned MaxLock   = DefMaxLock
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  sram_port_arbiter_if.slave     bus,
  output logic                   sram_req_o,
  output logic                   sram_we_o,
  output logic [AddrWidth-1:0]   sram_addr_o,
  output logic [DataWidth-1:0]   sram_wdata_o,
  output logic [DataWidth/8-1:0] sram_be_o,
  input  logic [DataWidth-1:0]   sram_rdata_i
);

  localparam int unsigned IdxW = $clog2(NumPorts);
  localparam int unsigned CntW = lock_cnt_width(MaxLock);

  state_e              state_q;
  logic [IdxW-1:0]     owner_q, ptr_q, gnt_idx, pick_idx, next_ptr;
  logic [CntW-1:0]     cnt_q, streak;
  logic [NumPorts-1:0] pick_gnt, gnt, rvalid_q;
  logic                pick_vld, owner_hold, gnt_vld, keep_lock;

  sram_rr_picker #(.NumPorts(NumPorts)) u_picker (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  // A locked owner that still requests overrides the rotation; otherwise fall straight to the picker.
  assign owner_hold = (state_q == LOCKED) && bus.req[owner_q];

  always_comb begin
    gnt     = pick_gnt;
    gnt_idx = pick_idx;
    gnt_vld = pick_vld;
    if (owner_hold) begin
      gnt          = '0;
      gnt[owner_q] = 1'b1;
      gnt_idx      = owner_q;
      gnt_vld      = 1'b1;
    end
  end

  assign streak    = owner_hold ? cnt_q + CntW'(1) : CntW'(1);
  assign keep_lock = bus.lock[gnt_idx] && (streak < CntW'(MaxLock));
  assign next_ptr  = (gnt_idx == IdxW'(NumPorts - 1)) ? '0 : gnt_idx + IdxW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ARB;
      owner_q  <= '0;
      cnt_q    <= '0;
      ptr_q    <= '0;
      rvalid_q <= '0;
    end else begin
      rvalid_q <= gnt;
      if (gnt_vld) begin
        // Pointer always moves past the winner, so a forced release skips the old owner.
        ptr_q <= next_ptr;
        if (keep_lock) begin
          state_q <= LOCKED;
          owner_q <= gnt_idx;
          cnt_q   <= streak;
        end else begin
          state_q <= ARB;
          cnt_q   <= '0;
        end
      end else begin
        state_q <= ARB;
        cnt_q   <= '0;
      end
    end
  end

  assign bus.gnt      = gnt;
  assign bus.rvalid   = rvalid_q;
  assign bus.rdata    = sram_rdata_i;
  assign sram_req_o   = gnt_vld;
  assign sram_we_o    = gnt_vld & bus.we[gnt_idx];
  assign sram_addr_o  = gnt_vld ? bus.addr[gnt_idx]  : '0;
  assign sram_wdata_o = gnt_vld ? bus.wdata[gnt_idx] : '0;
  assign sram_be_o    = gnt_vld ? bus.be[gnt_idx]    : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a queue-free behavioural model of round-robin with bounded locking.
module tb_sram_port_arbiter;
  import mem_arb_pkg::*;

  localparam int N  = 2;
  localparam int AW = 13;
  localparam int DW = 64;
  localparam int ML = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          sram_req, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;
  logic [7:0]    sram_be;
  logic [DW-1:0] sram_mem [16];

  int n_checks = 0;
  int n_fail   = 0;

  sram_port_arbiter_if #(.NumPorts(N), .AddrWidth(AW), .DataWidth(DW)) bus ();

  sram_port_arbiter #(.NumPorts(N), .AddrWidth(AW), .DataWidth(DW), .MaxLock(ML)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .bus          (bus),
    .sram_req_o   (sram_req),
    .sram_we_o    (sram_we),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_be_o    (sram_be),
    .sram_rdata_i (sram_rdata)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [63:0] be_mask(input logic [7:0] be);
    logic [63:0] m;
    logic [7:0]  b;
    m = '0;
    b = be;
    for (int k = 0; k < 8; k++) begin
      m[8*k +: 8] = {8{b[0]}};
      b = b >> 1;
    end
    return m;
  endfunction

  // Single-port SRAM with one cycle of read latency, 16 words aliased on the low address bits.
  always @(posedge clk_i) begin
    if (sram_req) begin
      if (sram_we)
        sram_mem[sram_addr[3:0]] <= (sram_mem[sram_addr[3:0]] & ~be_mask(sram_be)) |
                                    (sram_wdata & be_mask(sram_be));
      else
        sram_rdata <= sram_mem[sram_addr[3:0]];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner/streak/pointer as plain integers, advanced once per cycle.
  initial begin : compare
    int            m_ptr, m_owner, m_cnt, eg, streak, p;
    port_idx_t     gi;
    logic [N-1:0]  exp_gnt, exp_rv;
    logic [DW-1:0] exp_rd;
    logic          exp_rd_vld;
    logic [DW-1:0] ref_mem [16];
    logic          written [16];
    logic [3:0]    ai;
    m_ptr = 0; m_owner = -1; m_cnt = 0; exp_rv = '0; exp_rd = '0; exp_rd_vld = 1'b0;
    for (int k = 0; k < 16; k++) begin
      ref_mem[k] = '0;
      written[k] = 1'b0;
    end
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        m_ptr = 0; m_owner = -1; m_cnt = 0; exp_rv = '0;
      end
      eg = -1;
      if (m_owner >= 0) begin
        gi = port_idx_t'(m_owner);
        if (bus.req[gi]) eg = m_owner;
      end
      for (int k = 0; k < N; k++) begin
        p  = (m_ptr + k) % N;
        gi = port_idx_t'(p);
        if (eg < 0 && bus.req[gi]) eg = p;
      end
      exp_gnt = '0;
      gi = port_idx_t'(eg < 0 ? 0 : eg);
      if (eg >= 0) exp_gnt[gi] = 1'b1;
      check("gnt", 64'(bus.gnt), 64'(exp_gnt));
      check("sram_req", 64'(sram_req), 64'(eg >= 0));
      check("sram_we", 64'(sram_we), 64'(eg >= 0 && bus.we[gi]));
      check("sram_addr", 64'(sram_addr), eg >= 0 ? 64'(bus.addr[gi]) : 64'd0);
      check("sram_wdata", sram_wdata, eg >= 0 ? bus.wdata[gi] : 64'd0);
      check("sram_be", 64'(sram_be), eg >= 0 ? 64'(bus.be[gi]) : 64'd0);
      check("rvalid", 64'(bus.rvalid), 64'(exp_rv));
      if (exp_rv != '0 && exp_rd_vld) check("rdata", bus.rdata, exp_rd);
      if (rst_ni) begin
        exp_rv     = exp_gnt;
        exp_rd_vld = 1'b0;
        if (eg >= 0) begin
          ai = bus.addr[gi][3:0];
          if (bus.we[gi]) begin
            ref_mem[ai] = (ref_mem[ai] & ~be_mask(bus.be[gi])) | (bus.wdata[gi] & be_mask(bus.be[gi]));
            written[ai] = 1'b1;
          end else begin
            exp_rd     = ref_mem[ai];
            exp_rd_vld = written[ai];
          end
          streak = (eg == m_owner) ? m_cnt + 1 : 1;
          m_ptr  = (eg + 1) % N;
          if (bus.lock[gi] && streak < ML) begin
            m_owner = eg; m_cnt = streak;
          end else begin
            m_owner = -1; m_cnt = 0;
          end
        end else begin
          m_owner = -1; m_cnt = 0;
        end
      end
    end
  end

  task automatic cyc(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [DW-1:0] d);
    @(posedge clk_i); #1;
    bus.req = r; bus.lock = l; bus.we = w;
    bus.addr = {a1, a0}; bus.wdata = {d, d}; bus.be = '1;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_ni = 1'b0; bus.req = '0; bus.lock = '0; bus.we = '0;
    @(negedge clk_i);
    check("rst_rvalid", 64'(bus.rvalid), 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  initial begin : stim
    logic [N-1:0] last_gnt;
    port_idx_t    gi;
    bus.req = '0; bus.lock = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0; bus.be = '0;
    #2 rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    check("reset_gnt", 64'(bus.gnt), 64'd0);
    check("reset_sram_req", 64'(sram_req), 64'd0);
    check("reset_rvalid", 64'(bus.rvalid), 64'd0);
    @(posedge clk_i); #1 rst_ni = 1'b1;

    // Single port write then read back.
    cyc(2'b01, 2'b00, 2'b01, 13'd5, 13'd0, 64'hDEAD_BEEF);
    check("t1_wr_gnt", 64'(bus.gnt), 64'h1);
    cyc(2'b01, 2'b00, 2'b00, 13'd5, 13'd0, 64'd0);
    check("t1_rd_gnt", 64'(bus.gnt), 64'h1);
    check("t1_wr_rvalid", 64'(bus.rvalid), 64'h1);
    cyc(2'b00, 2'b00, 2'b00, 13'd0, 13'd0, 64'd0);
    check("t1_rd_rvalid", 64'(bus.rvalid), 64'h1);
    check("t1_rdata", bus.rdata, 64'hDEAD_BEEF);

    // Both ports, no lock: strict alternation.
    do_reset();
    cyc(2'b11, 2'b00, 2'b00, 13'd1, 13'd2, 64'd0);
    check("t2_gnt0", 64'(bus.gnt), 64'h1);
    cyc(2'b11, 2'b00, 2'b00, 13'd1, 13'd2, 64'd0);
    check("t2_gnt1", 64'(bus.gnt), 64'h2);
    check("t2_rv1", 64'(bus.rvalid), 64'h1);
    cyc(2'b11, 2'b00, 2'b00, 13'd1, 13'd2, 64'd0);
    check("t2_gnt2", 64'(bus.gnt), 64'h1);
    check("t2_rv2", 64'(bus.rvalid), 64'h2);

    // Port 1 lock bounded at MaxLock grants.
    do_reset();
    cyc(2'b10, 2'b10, 2'b00, 13'd0, 13'd0, 64'd0);
    check("t3_lock_gnt0", 64'(bus.gnt), 64'h2);
    for (int k = 1; k < 4; k++) begin
      cyc(2'b11, 2'b10, 2'b00, 13'd0, 13'd0, 64'd0);
      check("t3_lock_gnt", 64'(bus.gnt), 64'h2);
    end
    cyc(2'b11, 2'b10, 2'b00, 13'd0, 13'd0, 64'd0);
    check("t3_forced_p0", 64'(bus.gnt), 64'h1);
    cyc(2'b11, 2'b10, 2'b00, 13'd0, 13'd0, 64'd0);
    check("t3_then_p1", 64'(bus.gnt), 64'h2);

    // Owner drops req: other port served same cycle.
    do_reset();
    cyc(2'b01, 2'b01, 2'b00, 13'd0, 13'd0, 64'd0);
    check("t4_gnt0", 64'(bus.gnt), 64'h1);
    cyc(2'b11, 2'b01, 2'b00, 13'd0, 13'd0, 64'd0);
    check("t4_locked", 64'(bus.gnt), 64'h1);
    cyc(2'b10, 2'b00, 2'b00, 13'd0, 13'd0, 64'd0);
    check("t4_release", 64'(bus.gnt), 64'h2);

    // Response follows the issuing port across a grant switch.
    do_reset();
    cyc(2'b01, 2'b00, 2'b00, 13'd5, 13'd6, 64'd0);
    check("t5_gnt0", 64'(bus.gnt), 64'h1);
    cyc(2'b10, 2'b00, 2'b00, 13'd5, 13'd6, 64'd0);
    check("t5_gnt1", 64'(bus.gnt), 64'h2);
    check("t5_rv0", 64'(bus.rvalid), 64'h1);
    check("t5_rdata0", bus.rdata, 64'hDEAD_BEEF);
    cyc(2'b00, 2'b00, 2'b00, 13'd0, 13'd0, 64'd0);
    check("t5_rv1", 64'(bus.rvalid), 64'h2);

    // Reset right after a grant drops the response and rewinds the pointer.
    do_reset();
    cyc(2'b01, 2'b00, 2'b00, 13'd3, 13'd0, 64'd0);
    check("t6_gnt", 64'(bus.gnt), 64'h1);
    do_reset();
    check("t6_post_rvalid", 64'(bus.rvalid), 64'd0);
    cyc(2'b11, 2'b00, 2'b00, 13'd3, 13'd4, 64'd0);
    check("t6_ptr0", 64'(bus.gnt), 64'h1);
    cyc(2'b00, 2'b00, 2'b00, 13'd0, 13'd0, 64'd0);

    // Randomized traffic; a waiting requester keeps its fields stable.
    last_gnt = '0;
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        last_gnt = '0;
      end
      @(posedge clk_i); #1;
      for (int k = 0; k < N; k++) begin
        gi = port_idx_t'(k);
        if (!bus.req[gi] || last_gnt[gi]) begin
          bus.req[gi]   = ($urandom_range(0, 9) < 7);
          bus.we[gi]    = ($urandom_range(0, 1) == 1);
          bus.addr[gi]  = AW'($urandom);
          bus.wdata[gi] = {$urandom, $urandom};
          bus.be[gi]    = 8'($urandom);
        end
        bus.lock[gi] = ($urandom_range(0, 9) < 5);
      end
      @(negedge clk_i);
      last_gnt = bus.gnt;
    end

    @(posedge clk_i); #1;
    bus.req = '0;
    @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
